// File: rtl/register_file_wb_if.sv
// Write-back / register-fetch bus of the SPU register file: two write-back
// packets, stall, five read addresses, five read data words and status.
interface register_file_wb_if #(
  parameter int unsigned UNIT_ID_SIZE   = 3,
  parameter int unsigned REG_ADDR_WIDTH = 7,
  parameter int unsigned QUADWORD       = 128
);
  localparam int unsigned PKT_W = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD;
  localparam int unsigned CNT_W = 16;

  // Packets are big-endian: index 0 is the MSB of the unit ID.
  logic [0:PKT_W-1]          wb_even;
  logic [0:PKT_W-1]          wb_odd;
  logic                      stall;
  logic [REG_ADDR_WIDTH-1:0] ra_addr_even;
  logic [REG_ADDR_WIDTH-1:0] rb_addr_even;
  logic [REG_ADDR_WIDTH-1:0] rc_addr_even;
  logic [REG_ADDR_WIDTH-1:0] ra_addr_odd;
  logic [REG_ADDR_WIDTH-1:0] rb_addr_odd;
  logic [QUADWORD-1:0]       ra_rd_even;
  logic [QUADWORD-1:0]       rb_rd_even;
  logic [QUADWORD-1:0]       rc_rd_even;
  logic [QUADWORD-1:0]       ra_rd_odd;
  logic [QUADWORD-1:0]       rb_rd_odd;
  logic                      wb_collision;
  logic [CNT_W-1:0]          wb_count;

  modport master (
    output wb_even, wb_odd, stall,
    output ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd,
    input  ra_rd_even, rb_rd_even, rc_rd_even, ra_rd_odd, rb_rd_odd,
    input  wb_collision, wb_count
  );

  modport slave (
    input  wb_even, wb_odd, stall,
    input  ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd,
    output ra_rd_even, rb_rd_even, rc_rd_even, ra_rd_odd, rb_rd_odd,
    output wb_collision, wb_count
  );
endinterface

// File: rtl/register_file_wb.sv
// Write-back stage and 128 x 128-bit unified register file with five registered read ports.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle write data into the read registers.
module register_file_wb #(
  parameter int unsigned UNIT_ID_SIZE   = 3,
  parameter int unsigned REG_ADDR_WIDTH = 7,
  parameter int unsigned QUADWORD       = 128
) (
  input logic               clk,
  input logic               reset,
  register_file_wb_if.slave bus
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam int unsigned NUM_RD   = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam int unsigned ADDR_LO  = UNIT_ID_SIZE + 1;
  localparam int unsigned DATA_LO  = ADDR_LO + REG_ADDR_WIDTH;

  logic [QUADWORD-1:0]       regs_q [NUM_REGS];
  logic [QUADWORD-1:0]       regs_d [NUM_REGS];
  logic [QUADWORD-1:0]       rd_q   [NUM_RD];
  logic [QUADWORD-1:0]       rd_d   [NUM_RD];
  logic                      wb_collision_q, wb_collision_d;
  logic [CNT_W-1:0]          wb_count_q, wb_count_d;

  logic                      even_live_c, odd_live_c;
  logic [REG_ADDR_WIDTH-1:0] even_addr_c, odd_addr_c;
  logic [QUADWORD-1:0]       even_data_c, odd_data_c;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_c [NUM_RD];
  logic [1:0]                n_live_c;
  logic [SUM_W-1:0]          sum_c;

  // Packet decode: live needs the write flag and a non-zero unit ID.
  always_comb begin
    even_live_c = bus.wb_even[UNIT_ID_SIZE] && (bus.wb_even[0:UNIT_ID_SIZE-1] != '0);
    odd_live_c  = bus.wb_odd[UNIT_ID_SIZE]  && (bus.wb_odd[0:UNIT_ID_SIZE-1]  != '0);
    even_addr_c = bus.wb_even[ADDR_LO +: REG_ADDR_WIDTH];
    odd_addr_c  = bus.wb_odd[ADDR_LO +: REG_ADDR_WIDTH];
    even_data_c = bus.wb_even[DATA_LO +: QUADWORD];
    odd_data_c  = bus.wb_odd[DATA_LO +: QUADWORD];
  end

  always_comb begin
    rd_addr_c[0] = bus.ra_addr_even;
    rd_addr_c[1] = bus.rb_addr_even;
    rd_addr_c[2] = bus.rc_addr_even;
    rd_addr_c[3] = bus.ra_addr_odd;
    rd_addr_c[4] = bus.rb_addr_odd;
  end

  // Commit: odd is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (even_live_c) begin
      regs_d[even_addr_c] = even_data_c;
    end
    if (odd_live_c) begin
      regs_d[odd_addr_c] = odd_data_c;
    end
  end

  // Read capture from the pre-write array; optional bypass follows collision priority.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_d[p] = rd_q[p];
      if (!bus.stall) begin
        rd_d[p] = regs_q[rd_addr_c[p]];
`ifdef REGFILE_WB_BYPASS_EN
        if (odd_live_c && (odd_addr_c == rd_addr_c[p])) begin
          rd_d[p] = odd_data_c;
        end else if (even_live_c && (even_addr_c == rd_addr_c[p])) begin
          rd_d[p] = even_data_c;
        end
`endif
      end
    end
  end

  // Status: collision pulse and saturating commit counter.
  always_comb begin
    wb_collision_d = even_live_c && odd_live_c && (even_addr_c == odd_addr_c);
    n_live_c       = 2'(even_live_c) + 2'(odd_live_c);
    sum_c          = SUM_W'(wb_count_q) + SUM_W'(n_live_c);
    wb_count_d     = sum_c[CNT_W] ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= '0;
      end
      wb_collision_q <= 1'b0;
      wb_count_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      for (int p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= rd_d[p];
      end
      wb_collision_q <= wb_collision_d;
      wb_count_q     <= wb_count_d;
    end
  end

  assign bus.ra_rd_even   = rd_q[0];
  assign bus.rb_rd_even   = rd_q[1];
  assign bus.rc_rd_even   = rd_q[2];
  assign bus.ra_rd_odd    = rd_q[3];
  assign bus.rb_rd_odd    = rd_q[4];
  assign bus.wb_collision = wb_collision_q;
  assign bus.wb_count     = wb_count_q;

endmodule

// File: doc/register_file_wb.md
# register_file_wb

Write-back stage and 128-entry × 128-bit unified register file of the dual-issue SPU. It consumes the even- and odd-pipe write-back packets leaving the forwarding macro at stage 8 (FWE8/FWO8), and commits them to the architectural register file. It also serves the five register-fetch read ports (three even, two odd) with a registered, one-cycle read. Optionally, it bypasses same-cycle writes into the read data.

## Interface
- UNIT_ID_SIZE, 3: width of the execution-unit ID field in a write-back packet.
- REG_ADDR_WIDTH, 7: register address width (128 registers).
- QUADWORD, 128: register data width.
- PKT_W, UNIT_ID_SIZE+1+REG_ADDR_WIDTH+QUADWORD: derived packet width.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- wb_even  in  PKT_W  even-pipe write-back packet (FWE8).
- wb_odd  in  PKT_W  odd-pipe write-back packet (FWO8).
- stall  in  1  hold read outputs; writes still commit.
- ra_addr_even, rb_addr_even, rc_addr_even  in  REG_ADDR_WIDTH  even-pipe read addresses.
- ra_addr_odd, rb_addr_odd  in  REG_ADDR_WIDTH  odd-pipe read addresses.
- ra_rd_even, rb_rd_even, rc_rd_even  out  QUADWORD  registered even read data.
- ra_rd_odd, rb_rd_odd  out  QUADWORD  registered odd read data.
- wb_collision  out  1  registered pulse: both pipes wrote the same register in one cycle.
- wb_count  out  16  count of committed register writes, saturating.

## Operation
- Packet layout, big-endian [0:PKT_W-1]:
  - unit ID in [0:UNIT_ID_SIZE-1];
  - write flag at bit UNIT_ID_SIZE;
  - register address in the next REG_ADDR_WIDTH bits;
  - data in the last QUADWORD bits.
- A packet is live when the write flag = 1 and unit ID ≠ 0. Any other packet is a bubble and is ignored.
- Commit: each live packet writes data to regfile[addr] at the posedge.
- Collision (both live, same address): the odd packet's data is written. wb_collision = 1 the following cycle, otherwise 0.
- wb_count increments by the number of live packets per cycle (0, 1, 2). A collision counts as 2. It saturates at 16'hFFFF.
- Reads: each read port samples regfile[addr] at posedge into its output register.
- When stall = 1, all five read output registers hold their value. Addresses are ignored.
- Register 0 is an ordinary writable register; there is no hardwired zero.
- Reset asserted (low), at any time including mid-write: all 128 registers, all five read outputs, wb_collision and wb_count go to 0 asynchronously. Packets present during reset are discarded.
- Reset release: the first commit occurs at the first posedge with reset high.

## Timing
- Write latency: a packet valid at edge N is visible in regfile after edge N.
- Read latency: 1 cycle. An address at edge N yields data on the outputs after edge N.
- Read and write of the same address in the same cycle: result is set by WB_BYPASS_EN (see Configuration).
- A read issued in cycle N+1 or later after a write at edge N always returns the new data.
- wb_collision and wb_count update at the same edge as the commit they describe. wb_collision is therefore observable one cycle after the packets.
- No handshake; the block never backpressures. The upstream forwarding pipeline is fire-and-forget.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - a read port whose address matches a live write packet in the same cycle captures the packet data instead of the stored value;
  - if both packets match, the odd packet's data is captured, consistent with collision priority;
  - the bypass also applies while stall = 0 only; stalled outputs hold.
- REGFILE_WB_BYPASS_EN undefined:
  - a same-cycle read returns the pre-write (old) value;
  - the new value appears on a read issued the next cycle.

## Test plan
- Reset: after power-on, write r5 = 0xAAAA…; assert reset low mid-cycle -> all outputs, wb_count and r5 read back 0; wb_collision = 0.
- Single write then read: wb_even = {unit 1, we 1, r10, 0x0123…CDEF} at edge N; ra_addr_even = 10 at edge N+1 -> ra_rd_even = 0x0123…CDEF after N+1; wb_count = 1.
- Collision: wb_even and wb_odd both live to r20, data 0x11…11 and 0x22…22 -> r20 = 0x22…22; wb_collision = 1 for exactly one cycle; wb_count += 2.
- Bubble filtering: packets with unit ID 0 (write flag 1), or write flag 0 (unit ID 3), targeting r7 -> r7 unchanged; wb_count unchanged.
- Same-cycle read/write of r30 (old 0x5, new 0x9): with REGFILE_WB_BYPASS_EN, rb_rd_odd = 0x9; without it, rb_rd_odd = 0x5, and the next-cycle read returns 0x9.
- Stall: hold stall = 1 for 3 cycles while changing addresses and writing the addressed register -> outputs unchanged. After release, outputs show the new data after one cycle.
